// File: rtl/clock_set_controller_if.sv
// rtl/clock_set_controller_if.sv - buttons, live digits and adjust bus of the time-setting sequencer
// master: button panel and counter side; slave: the set controller.
interface clock_set_controller_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_dec;
  logic [3:0] cur_hour_tens;
  logic [3:0] cur_hour_units;
  logic [3:0] cur_min_tens;
  logic [3:0] cur_min_units;
  logic [3:0] cur_sec_tens;
  logic [3:0] cur_sec_units;
  logic       adjust;
  logic [5:0] adjust_hour;
  logic [5:0] adjust_min;
  logic [5:0] adjust_sec;
  logic [1:0] sel_field;
  logic       blink;

  modport master (
    output btn_mode, btn_inc, btn_dec,
    output cur_hour_tens, cur_hour_units, cur_min_tens, cur_min_units,
    output cur_sec_tens, cur_sec_units,
    input  adjust, adjust_hour, adjust_min, adjust_sec, sel_field, blink
  );

  modport slave (
    input  btn_mode, btn_inc, btn_dec,
    input  cur_hour_tens, cur_hour_units, cur_min_tens, cur_min_units,
    input  cur_sec_tens, cur_sec_units,
    output adjust, adjust_hour, adjust_min, adjust_sec, sel_field, blink
  );
endinterface

// File: rtl/clock_set_controller.sv
// rtl/clock_set_controller.sv - button-driven hh:mm:ss time-setting sequencer
// Hold-to-repeat stepping is built only when CLOCK_SET_AUTOREPEAT_EN is defined.
module clock_set_controller #(
  parameter int BLINK_DIV     = 25000000,
`ifdef CLOCK_SET_AUTOREPEAT_EN
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
`endif
  parameter int TIMEOUT       = 500000000
) (
  input logic                   clk,
  input logic                   reset,
  clock_set_controller_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam int TO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT - 1);
  localparam logic [5:0] HOUR_MAX = 6'd23;
  localparam logic [5:0] MS_MAX   = 6'd59;

  state_t               state_q, state_d;
  logic [5:0]           hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic                 mode_hist_q, mode_hist_d;
  logic                 inc_hist_q, inc_hist_d;
  logic                 dec_hist_q, dec_hist_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                 blink_q, blink_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;

  logic mode_edge, inc_edge, dec_edge, any_edge, in_set;
  logic rep_inc, rep_dec, step_inc, step_dec, activity, state_change;

  // Tens above 5 can never be a legal field, which keeps the 6-bit product from overflowing.
  function automatic logic [5:0] capture(input logic [3:0] tens, input logic [3:0] units,
                                         input logic [5:0] max_val);
    logic [5:0] v;
    v = 6'(tens) * 6'd10 + 6'(units);
    if (tens > 4'd5 || units > 4'd9 || v > max_val) return 6'd0;
    return v;
  endfunction

  function automatic logic [5:0] step_field(input logic [5:0] v, input logic up,
                                            input logic [5:0] max_val);
    if (up) return (v == max_val) ? 6'd0 : v + 6'd1;
    return (v == 6'd0) ? max_val : v - 6'd1;
  endfunction

  assign mode_edge = bus.btn_mode & ~mode_hist_q;
  assign inc_edge  = bus.btn_inc & ~inc_hist_q;
  assign dec_edge  = bus.btn_dec & ~dec_hist_q;
  assign any_edge  = mode_edge | inc_edge | dec_edge;
  assign in_set    = (state_q != RUN);
  assign step_inc  = in_set & ~mode_edge & ((inc_edge & ~dec_edge) | rep_inc);
  assign step_dec  = in_set & ~mode_edge & ((dec_edge & ~inc_edge) | rep_dec);
  assign activity  = any_edge | rep_inc | rep_dec;

`ifdef CLOCK_SET_AUTOREPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              repeating_q, repeating_d;
  logic              held;

  always_comb begin
    hold_cnt_d  = hold_cnt_q;
    repeating_d = repeating_q;
    rep_inc     = 1'b0;
    rep_dec     = 1'b0;
    held        = in_set & (bus.btn_inc ^ bus.btn_dec) & ~mode_edge;
    if (!held || inc_edge || dec_edge) begin
      hold_cnt_d  = '0;
      repeating_d = 1'b0;
    end else if ((!repeating_q && hold_cnt_q == HOLD_W'(REPEAT_DELAY - 1)) ||
                 (repeating_q && hold_cnt_q == HOLD_W'(REPEAT_PERIOD - 1))) begin
      hold_cnt_d  = '0;
      repeating_d = 1'b1;
      rep_inc     = bus.btn_inc;
      rep_dec     = bus.btn_dec;
    end else begin
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt_q  <= '0;
      repeating_q <= 1'b0;
    end else begin
      hold_cnt_q  <= hold_cnt_d;
      repeating_q <= repeating_d;
    end
  end
`else
  assign rep_inc = 1'b0;
  assign rep_dec = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    hour_d      = hour_q;
    min_d       = min_q;
    sec_d       = sec_q;
    mode_hist_d = bus.btn_mode;
    inc_hist_d  = bus.btn_inc;
    dec_hist_d  = bus.btn_dec;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    to_cnt_d    = to_cnt_q;

    case (state_q)
      RUN: begin
        if (mode_edge) begin
          hour_d  = capture(bus.cur_hour_tens, bus.cur_hour_units, HOUR_MAX);
          min_d   = capture(bus.cur_min_tens, bus.cur_min_units, MS_MAX);
          sec_d   = capture(bus.cur_sec_tens, bus.cur_sec_units, MS_MAX);
          state_d = SET_HOUR;
        end
      end
      SET_HOUR: begin
        if (mode_edge) state_d = SET_MIN;
        else if (step_inc || step_dec) hour_d = step_field(hour_q, step_inc, HOUR_MAX);
      end
      SET_MIN: begin
        if (mode_edge) state_d = SET_SEC;
        else if (step_inc || step_dec) min_d = step_field(min_q, step_inc, MS_MAX);
      end
      SET_SEC: begin
        if (mode_edge) state_d = RUN;
        else if (step_inc || step_dec) sec_d = step_field(sec_q, step_inc, MS_MAX);
      end
      default: state_d = RUN;
    endcase

    // Any press in the last idle cycle counts as activity and pre-empts the timeout.
    if (in_set && !activity && to_cnt_q == TO_LAST) state_d = RUN;

    state_change = (state_d != state_q);

    if (!in_set || state_change || activity) to_cnt_d = '0;
    else                                     to_cnt_d = to_cnt_q + TO_W'(1);

    if (!in_set || state_change || step_inc || step_dec) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      hour_q      <= 6'd0;
      min_q       <= 6'd0;
      sec_q       <= 6'd0;
      mode_hist_q <= 1'b0;
      inc_hist_q  <= 1'b0;
      dec_hist_q  <= 1'b0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      mode_hist_q <= mode_hist_d;
      inc_hist_q  <= inc_hist_d;
      dec_hist_q  <= dec_hist_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign bus.adjust      = in_set;
  assign bus.sel_field   = state_q;
  assign bus.blink       = blink_q;
  assign bus.adjust_hour = hour_q;
  assign bus.adjust_min  = min_q;
  assign bus.adjust_sec  = sec_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// tb/tb_clock_set_controller.sv - directed vectors, corner sequences and random run against a timestamp model
module tb_clock_set_controller;
  localparam int BLINK_DIV = 3;
  localparam int TIMEOUT   = 20;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  clock_set_controller_if bus_if();

  clock_set_controller #(.BLINK_DIV(BLINK_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: edit field, working values and timestamps of the last timeout/blink restart.
  int cyc, m_field, m_h, m_m, m_s, last_to, last_bl;
  bit pm, pi, pd;

  function automatic int cap(input int t, input int u, input int mx);
    int v;
    v = t * 10 + u;
    if (t > 9 || u > 9 || v > mx) return 0;
    return v;
  endfunction

  task automatic model_reset();
    m_field = 0; m_h = 0; m_m = 0; m_s = 0;
    pm = 0; pi = 0; pd = 0;
    last_to = cyc; last_bl = cyc;
  endtask

  task automatic model_step();
    bit me, ie, de;
    int mx;
    cyc++;
    me = bus_if.btn_mode && !pm;
    ie = bus_if.btn_inc && !pi;
    de = bus_if.btn_dec && !pd;
    if (m_field == 0) begin
      if (me) begin
        m_h = cap(bus_if.cur_hour_tens, bus_if.cur_hour_units, 23);
        m_m = cap(bus_if.cur_min_tens, bus_if.cur_min_units, 59);
        m_s = cap(bus_if.cur_sec_tens, bus_if.cur_sec_units, 59);
        m_field = 1; last_to = cyc; last_bl = cyc;
      end
    end else if (me) begin
      m_field = (m_field + 1) % 4;
      last_to = cyc; last_bl = cyc;
    end else begin
      if (ie != de) begin
        mx = (m_field == 1) ? 24 : 60;
        if (m_field == 1) m_h = ie ? (m_h + 1) % mx : (m_h + mx - 1) % mx;
        if (m_field == 2) m_m = ie ? (m_m + 1) % mx : (m_m + mx - 1) % mx;
        if (m_field == 3) m_s = ie ? (m_s + 1) % mx : (m_s + mx - 1) % mx;
        last_bl = cyc;
      end
      if (ie || de) last_to = cyc;
      else if (cyc - last_to == TIMEOUT) m_field = 0;
    end
    pm = bus_if.btn_mode; pi = bus_if.btn_inc; pd = bus_if.btn_dec;
  endtask

  function automatic int exp_blink();
    if (m_field == 0) return 0;
    return ((cyc - last_bl) / BLINK_DIV) % 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_model();
    check("rnd_sel", 32'(bus_if.sel_field), m_field);
    check("rnd_adjust", 32'(bus_if.adjust), (m_field != 0) ? 1 : 0);
    check("rnd_hour", 32'(bus_if.adjust_hour), m_h);
    check("rnd_min", 32'(bus_if.adjust_min), m_m);
    check("rnd_sec", 32'(bus_if.adjust_sec), m_s);
    check("rnd_blink", 32'(bus_if.blink), exp_blink());
  endtask

  task automatic set_digits(input int ht, input int hu, input int mt, input int mu,
                            input int st, input int su);
    bus_if.cur_hour_tens = 4'(ht); bus_if.cur_hour_units = 4'(hu);
    bus_if.cur_min_tens  = 4'(mt); bus_if.cur_min_units  = 4'(mu);
    bus_if.cur_sec_tens  = 4'(st); bus_if.cur_sec_units  = 4'(su);
  endtask

  task automatic set_btn(input bit m, input bit i, input bit d);
    bus_if.btn_mode = m; bus_if.btn_inc = i; bus_if.btn_dec = d;
  endtask

  typedef struct {
    bit m, i, d;
    int sel, adj, h, mi, s;
  } vec_t;
  vec_t vt[$];

  task automatic add(input bit m, input bit i, input bit d, input int sel, input int adj,
                     input int h, input int mi, input int s);
    vec_t v;
    v.m = m; v.i = i; v.d = d; v.sel = sel; v.adj = adj; v.h = h; v.mi = mi; v.s = s;
    vt.push_back(v);
  endtask

  initial begin
    int k, rate;
    n_checks = 0; n_fail = 0; cyc = 0;
    reset = 1'b1;
    set_btn(0, 0, 0);
    set_digits(0, 0, 0, 0, 0, 0);
    model_reset();

    add(0,0,0, 0,0,  0, 0, 0);
    add(1,0,0, 1,1, 23,59,58);
    add(0,0,0, 1,1, 23,59,58);
    add(0,1,0, 1,1,  0,59,58);
    add(0,0,0, 1,1,  0,59,58);
    add(0,0,1, 1,1, 23,59,58);
    add(0,0,0, 1,1, 23,59,58);
    add(0,1,1, 1,1, 23,59,58);
    add(0,0,0, 1,1, 23,59,58);
    add(1,0,0, 2,1, 23,59,58);
    add(0,0,0, 2,1, 23,59,58);
    add(0,1,0, 2,1, 23, 0,58);
    add(0,0,0, 2,1, 23, 0,58);
    add(0,0,1, 2,1, 23,59,58);
    add(0,0,0, 2,1, 23,59,58);
    add(0,1,0, 2,1, 23, 0,58);
    add(0,0,0, 2,1, 23, 0,58);
    add(1,0,0, 3,1, 23, 0,58);
    add(0,0,0, 3,1, 23, 0,58);
    add(0,1,0, 3,1, 23, 0,59);
    add(0,1,0, 3,1, 23, 0,59);
    add(0,0,0, 3,1, 23, 0,59);
    add(1,1,0, 0,0, 23, 0,59);
    add(0,0,0, 0,0, 23, 0,59);
    add(0,1,0, 0,0, 23, 0,59);
    add(0,0,0, 0,0, 23, 0,59);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    repeat (100) tick();
    check("idle_adjust", 32'(bus_if.adjust), 0);
    check("idle_sel", 32'(bus_if.sel_field), 0);
    check("idle_blink", 32'(bus_if.blink), 0);
    check("idle_hour", 32'(bus_if.adjust_hour), 0);
    check("idle_min", 32'(bus_if.adjust_min), 0);
    check("idle_sec", 32'(bus_if.adjust_sec), 0);

    set_digits(2, 3, 5, 9, 5, 8);
    for (int r = 0; r < vt.size(); r++) begin
      set_btn(vt[r].m, vt[r].i, vt[r].d);
      tick();
      check($sformatf("vec%0d_sel", r), 32'(bus_if.sel_field), vt[r].sel);
      check($sformatf("vec%0d_adjust", r), 32'(bus_if.adjust), vt[r].adj);
      check($sformatf("vec%0d_hour", r), 32'(bus_if.adjust_hour), vt[r].h);
      check($sformatf("vec%0d_min", r), 32'(bus_if.adjust_min), vt[r].mi);
      check($sformatf("vec%0d_sec", r), 32'(bus_if.adjust_sec), vt[r].s);
    end

    // Out-of-range captures: 31 h, 60 min, sec units digit 12.
    set_digits(3, 1, 6, 0, 5, 12);
    set_btn(1, 0, 0); tick();
    set_btn(0, 0, 0); tick();
    check("bad_hour", 32'(bus_if.adjust_hour), 0);
    check("bad_min", 32'(bus_if.adjust_min), 0);
    check("bad_sec", 32'(bus_if.adjust_sec), 0);
    check("bad_sel", 32'(bus_if.sel_field), 1);
    set_btn(0, 1, 0); tick();
    set_btn(0, 0, 0); tick();
    check("bad_then_inc", 32'(bus_if.adjust_hour), 1);

    set_btn(1, 0, 0); tick();
    set_btn(0, 0, 0); tick();
    check("pre_reset_sel", 32'(bus_if.sel_field), 2);
    #2 reset = 1'b1;
    #1;
    check("async_adjust", 32'(bus_if.adjust), 0);
    check("async_sel", 32'(bus_if.sel_field), 0);
    check("async_hour", 32'(bus_if.adjust_hour), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    set_digits(1, 2, 3, 4, 5, 6);
    set_btn(1, 0, 0); tick();
    set_btn(0, 0, 0); tick();
    set_btn(0, 1, 0); tick();
    set_btn(0, 0, 0);
    k = 1;
    while (k <= 100) begin
      tick();
      if (bus_if.sel_field == 2'd0) break;
      k++;
    end
    check("timeout_cycles", 32'(k), TIMEOUT);
    check("timeout_adjust", 32'(bus_if.adjust), 0);
    check("timeout_hour", 32'(bus_if.adjust_hour), 13);
    check("timeout_min", 32'(bus_if.adjust_min), 34);
    check("timeout_sec", 32'(bus_if.adjust_sec), 56);

    rate = 4;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) rate = ($urandom_range(0, 1) == 0) ? 4 : 60;
      if ($urandom_range(0, 39) == 0)
        set_digits($urandom_range(0, 3), $urandom_range(0, 11), $urandom_range(0, 6),
                   $urandom_range(0, 10), $urandom_range(0, 6), $urandom_range(0, 10));
      if ($urandom_range(0, rate - 1) == 0) bus_if.btn_mode = ~bus_if.btn_mode;
      if ($urandom_range(0, rate - 1) == 0) bus_if.btn_inc = ~bus_if.btn_inc;
      if ($urandom_range(0, rate - 1) == 0) bus_if.btn_dec = ~bus_if.btn_dec;
      tick();
      check_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
- Button-driven time-setting sequencer for the hh:mm:ss clock counter.
- Takes debounced mode/inc/dec buttons and the counter's current BCD digits.
- Walks an FSM through hour, minute and second edit fields, and drives the counter's adjust, adjust_hour, adjust_min and adjust_sec inputs.
- Produces a field-select code and a blink strobe for the display driver.

Parameters:
- BLINK_DIV, 25000000: clk cycles per blink half-period.
- TIMEOUT, 500000000: idle clk cycles in any edit state before automatic commit to RUN.
- REPEAT_DELAY, 25000000: hold cycles before auto-repeat starts (AUTOREPEAT_EN only).
- REPEAT_PERIOD, 5000000: cycles between repeated steps (AUTOREPEAT_EN only).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- btn_mode  input  1  debounced, synchronous level; rising edge advances the field
- btn_inc  input  1  debounced level; rising edge increments the field
- btn_dec  input  1  debounced level; rising edge decrements the field
- cur_hour_tens, cur_hour_units, cur_min_tens, cur_min_units, cur_sec_tens, cur_sec_units  input  4 each  live BCD digits from the counter
- adjust  output  1  load strobe to the counter
- adjust_hour  output  6  working hour, 0-23
- adjust_min  output  6  working minute, 0-59
- adjust_sec  output  6  working second, 0-59
- sel_field  output  2  0=RUN, 1=hour, 2=min, 3=sec
- blink  output  1  display blanking strobe for the selected field

Behaviour:
- Clock and reset: clock clk; reset reset, asynchronous, active-high.
- Reset values:
  - state RUN; adjust=0; adjust_hour/min/sec=0; sel_field=0; blink=0.
  - Blink and timeout counters 0; button history registers 0.
- Edge detection: one register per button. An edge is btn=1 while its history=0, both sampled at the same posedge. Responses appear on outputs after that posedge, giving 1-cycle latency.
- FSM states: RUN, SET_HOUR, SET_MIN, SET_SEC. sel_field is a direct encoding of the state.
- RUN:
  - adjust=0; adjust_* hold their last values.
  - mode edge: capture hour=tens*10+units, min, sec. Any captured value above its maximum (23/59/59) or any digit >9 loads 0. Go to SET_HOUR.
  - inc/dec edges ignored.
- SET_HOUR, SET_MIN, SET_SEC:
  - adjust=1 every cycle, so the counter is frozen to the working values.
  - mode edge transitions: SET_HOUR->SET_MIN->SET_SEC->RUN.
  - inc edge: field+1, wrapping 23->0 for hour and 59->0 for min/sec.
  - dec edge: field-1, wrapping 0->23 for hour and 0->59 for min/sec.
  - inc and dec edges in the same cycle: no change.
  - mode edge together with inc/dec in the same cycle: mode wins, the step is discarded.
- Commit: on entry to RUN, adjust drops to 0. The counter resumes from adjust_* at the next posedge, with no extra load cycle.
- Timeout:
  - The counter clears on any button edge and on state change, and increments each cycle while in a SET state.
  - At TIMEOUT-1 the next state is RUN, using the same commit behaviour.
  - The counter is held at 0 in RUN.
- Blink:
  - In SET states blink toggles every BLINK_DIV cycles.
  - Counter and blink clear to 0 on any state change and on any inc/dec step, so the field is visible immediately after a change.
  - blink=0 in RUN.
- Arithmetic: working registers are 6-bit. Increment/decrement use compare-then-wrap; modulo is not used. Capture uses a constant multiply by 10 on 4-bit digits.
- Reset mid-edit: returns to RUN with adjust=0 immediately (asynchronous). Working values clear to 0.
- Held buttons produce exactly one step per press, unless AUTOREPEAT_EN is defined.

Optional Feature:
- Macro: CLOCK_SET_AUTOREPEAT_EN.
- Defined:
  - While btn_inc or btn_dec is held alone in a SET state, a hold counter runs.
  - After REPEAT_DELAY cycles, one extra step is issued, then one step every REPEAT_PERIOD cycles.
  - Each step also clears the timeout and blink counters.
  - Release, a mode edge, or both buttons held resets the hold counter.
- Undefined: no hold counter logic; one step per rising edge only.

Test Plan:
- Reset, then idle 100 cycles -> adjust=0, sel_field=0, blink=0, adjust_*=0.
- Counter at 23:59:58, mode edge -> next cycle sel_field=1, adjust=1, adjust_hour=23, adjust_min=59, adjust_sec=58.
- In SET_HOUR at 23, inc edge -> adjust_hour=0. Dec edge -> 23. Inc and dec in the same cycle -> stays 23.
- Mode x3 from RUN with min=59 and one inc in SET_MIN -> adjust_min=0, sel_field back to 0, adjust falls the cycle after the third mode edge.
- In SET_SEC, mode and inc in the same cycle -> sel_field=0, adjust_sec unchanged. With TIMEOUT=20 and no buttons -> RUN exactly 20 cycles after last edge.
- Captured digits hour_tens=3, hour_units=1 (31) on mode edge -> adjust_hour=0. Assert reset during SET_MIN -> adjust=0 and sel_field=0 without a clock edge.
